stopwatch_timer: RTL and testbench
==================================

# stopwatch_timer

Single-clock, parametrised stopwatch/countdown core that replaces the divided-clock approach with a clock-enable prescaler running on the 50 MHz system clock. It counts in ticks (centiseconds by default) up or down with 1x/2x/4x/8x speed, start/pause/resume on one button, lap capture and a countdown alarm. Its `count` output feeds the existing seven-segment display path unchanged.

## Interface
- `CLK_HZ`, 50000000, system clock frequency
- `TICK_HZ`, 100, count rate at 1x; `DIV = CLK_HZ/TICK_HZ`, must be ≥ 8 (elaboration check)
- `WIDTH`, 16, width of count/preset/lap
- `MAX_COUNT`, 59999, highest count value (must fit WIDTH)
- `clk`  in  1  system clock; the block's one clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `ssp`  in  1  start/stop/pause button, active-high, asynchronous to clk
- `lap`  in  1  lap button, active-high, asynchronous to clk
- `clr`  in  1  synchronous clear to IDLE (level, clk domain)
- `speed`  in  2  0=1x, 1=2x, 2=4x, 3=8x; live
- `down`  in  1  1 = countdown mode; sampled only in IDLE
- `preset`  in  WIDTH  countdown start value; clamped to MAX_COUNT
- `count`  out  WIDTH  current time in ticks
- `lap_count`  out  WIDTH  last captured lap value
- `running`  out  1  high in RUN only
- `alarm`  out  1  high in DONE only

## Operation
- `ssp`, `lap`: each goes through a 2-flop synchroniser plus edge register; one rising-edge pulse per press.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE: `count` = 0 (up) or min(`preset`, MAX_COUNT) (down), every cycle; mode latched; prescaler held at 0; `lap` edge clears `lap_count`. `ssp` edge → RUN, except down mode with effective preset 0 → DONE directly.
- RUN: prescaler accumulator adds step 1/2/4/8 per clk; when acc + step ≥ DIV, tick fires and acc ← acc + step − DIV (exact rate, no drift). On tick: up mode counts +1, MAX_COUNT wraps to 0 with no alarm; down mode counts −1, reaching 0 → DONE on the same edge. `ssp` edge → PAUSE.
- PAUSE: count and accumulator held (fraction preserved). `ssp` edge → RUN.
- DONE: `count` = 0, `alarm` = 1. `ssp` edge → IDLE.
- `lap` edge in RUN/PAUSE/DONE: `lap_count` ← `count` value before this edge's update.
- `clr` high: → IDLE from any state, `lap_count` kept; `clr` has priority over `ssp`.
- Tick and `ssp` edge in the same RUN cycle: tick applied, then PAUSE.
- `speed` change mid-RUN applies to the next accumulate; acc is not reset.
- Accumulator width `$clog2(DIV+8)`; count arithmetic is WIDTH bits, never exceeds MAX_COUNT.

## Timing
- Reset (async): state IDLE, `count` 0, `lap_count` 0, `running` 0, `alarm` 0, acc 0, synchroniser flops 0; outputs change without a clk edge.
- Button latency: the press is acted on at the 3rd rising clk edge at which the input is sampled high (sync, sync, edge).
- First tick after RUN entry from IDLE at 1x: DIV clk cycles later.
- `running`/`alarm` are registered and change on the same edge as the state.
- All outputs registered; no combinational input→output paths.

## Test plan
- CLK_HZ=1000, TICK_HZ=100 (DIV=10), up, 1x: `ssp` press, 250 clk in RUN → `count`=25, `running`=1.
- Same setup, `speed`=3: 100 clk in RUN → `count`=80.
- 1x: 55 clk in RUN (`count`=5, acc=5), pause 100 clk → `count` stays 5; resume → next tick exactly 5 clk later.
- down=1, preset=3: press, 30 clk → `count`=0, `alarm`=1, `running`=0; press → IDLE, `alarm`=0, `count`=3. With preset=0, press → DONE directly.
- MAX_COUNT=9, up: 100 clk in RUN → `count`=0 after wrap, `alarm` never asserted; a `lap` press at `count`=7 → `lap_count`=7 while counting continues.
- Mid-RUN async `reset` pulse between clk edges → all outputs 0 immediately; `clr` in PAUSE → IDLE, `lap_count` preserved.

Source files
------------

// File: rtl/stopwatch_timer.sv
// Stopwatch / countdown core on a single system clock.
// A fractional clock-enable prescaler produces ticks at TICK_HZ times the
// selected speed (1x/2x/4x/8x) without drift. One button cycles through
// start/pause/resume, a second captures lap times, and countdown mode raises
// an alarm when the count reaches zero.
module stopwatch_timer #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 100,
    parameter int WIDTH     = 16,
    parameter int MAX_COUNT = 59999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ssp,
    input  logic             lap,
    input  logic             clr,
    input  logic [1:0]       speed,
    input  logic             down,
    input  logic [WIDTH-1:0] preset,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] lap_count,
    output logic             running,
    output logic             alarm
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int ACC_W = $clog2(DIV + 8);
    localparam logic [ACC_W-1:0] DIV_V = ACC_W'(DIV);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    // Largest step is 8, so a divider below 8 could need two ticks per clock.
    if (DIV < 8) begin : g_div_check
        $error("stopwatch_timer: CLK_HZ/TICK_HZ must be at least 8");
    end
    if (longint'(MAX_COUNT) >= (64'd1 << WIDTH)) begin : g_max_check
        $error("stopwatch_timer: MAX_COUNT does not fit in WIDTH bits");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] count_d, lap_d;
    logic [ACC_W-1:0] acc, acc_d, acc_sum;
    logic             mode, mode_d;
    logic [WIDTH-1:0] eff_preset, idle_count;
    logic [3:0]       step;
    logic             tick;

    logic ssp_meta, ssp_sync, ssp_prev;
    logic lap_meta, lap_sync, lap_prev;
    logic ssp_edge, lap_edge;

    // Button synchronisers plus edge registers: one pulse per press.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ssp_meta <= 1'b0;
            ssp_sync <= 1'b0;
            ssp_prev <= 1'b0;
            lap_meta <= 1'b0;
            lap_sync <= 1'b0;
            lap_prev <= 1'b0;
        end else begin
            ssp_meta <= ssp;
            ssp_sync <= ssp_meta;
            ssp_prev <= ssp_sync;
            lap_meta <= lap;
            lap_sync <= lap_meta;
            lap_prev <= lap_sync;
        end
    end

    assign ssp_edge = ssp_sync & ~ssp_prev;
    assign lap_edge = lap_sync & ~lap_prev;

    // Next-state, prescaler and counter datapath.
    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state;
        count_d    = count;
        lap_d      = lap_count;
        acc_d      = acc;
        mode_d     = mode;
        eff_preset = (preset > MAX_V) ? MAX_V : preset;
        idle_count = down ? eff_preset : '0;
        step       = 4'd1 << speed;
        acc_sum    = acc + ACC_W'(step);
        tick       = (acc_sum >= DIV_V);

        if (clr) begin
            // Clear wins over the button and leaves the lap value alone.
            state_d = IDLE;
            count_d = idle_count;
            acc_d   = '0;
            mode_d  = down;
        end else begin
            // Lap captures the value shown before this edge's update.
            if (lap_edge) begin
                lap_d = (state == IDLE) ? '0 : count;
            end

            case (state)
                IDLE: begin
                    count_d = idle_count;
                    acc_d   = '0;
                    mode_d  = down;
                    if (ssp_edge) begin
                        if (down && (eff_preset == '0)) begin
                            state_d = DONE;
                            count_d = '0;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    // Carry the remainder so the long-term rate is exact.
                    acc_d = tick ? (acc_sum - DIV_V) : acc_sum;
                    if (tick && mode && (count <= ONE)) begin
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        if (tick) begin
                            if (mode) begin
                                count_d = count - ONE;
                            end else begin
                                count_d = (count >= MAX_V) ? '0 : (count + ONE);
                            end
                        end
                        if (ssp_edge) begin
                            state_d = PAUSE;
                        end
                    end
                end
                PAUSE: begin
                    if (ssp_edge) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    count_d = '0;
                    acc_d   = '0;
                    if (ssp_edge) begin
                        state_d = IDLE;
                        count_d = idle_count;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; status flags follow the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            lap_count <= '0;
            acc       <= '0;
            mode      <= 1'b0;
            running   <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            lap_count <= lap_d;
            acc       <= acc_d;
            mode      <= mode_d;
            running   <= (state_d == RUN);
            alarm     <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Bench for stopwatch_timer: two instances (MAX_COUNT 59999 and 9) share one
// stimulus stream. A time-based reference model pushes expected outputs into
// queues at every clock edge; a monitor pops and compares on the falling edge.
module tb_stopwatch_timer;

    localparam int DIV = 10;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        ssp    = 1'b0;
    logic        lap    = 1'b0;
    logic        clr    = 1'b0;
    logic [1:0]  speed  = 2'd0;
    logic        down   = 1'b0;
    logic [15:0] preset = 16'd0;

    logic [15:0] count_a, lap_a, count_b, lap_b;
    logic        running_a, alarm_a, running_b, alarm_b;

    int total = 0;
    int bad   = 0;

    stopwatch_timer #(.CLK_HZ(1000), .TICK_HZ(100), .WIDTH(16), .MAX_COUNT(59999)) dut_a (
        .clk(clk), .reset(reset), .ssp(ssp), .lap(lap), .clr(clr), .speed(speed),
        .down(down), .preset(preset), .count(count_a), .lap_count(lap_a),
        .running(running_a), .alarm(alarm_a)
    );

    stopwatch_timer #(.CLK_HZ(1000), .TICK_HZ(100), .WIDTH(16), .MAX_COUNT(9)) dut_b (
        .clk(clk), .reset(reset), .ssp(ssp), .lap(lap), .clr(clr), .speed(speed),
        .down(down), .preset(preset), .count(count_b), .lap_count(lap_b),
        .running(running_b), .alarm(alarm_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
    typedef struct packed {
        logic [15:0] count;
        logic [15:0] lap;
        logic        running;
        logic        alarm;
    } obs_t;

    mstate_t m_state [2];
    bit      m_down  [2];
    int      m_steps [2];   // total speed-weighted clocks spent in RUN
    int      m_start [2];
    int      m_count [2];
    int      m_lap   [2];
    bit      ssp_h   [3];   // input as sampled at the last three edges
    bit      lap_h   [3];
    obs_t    exp_a[$];
    obs_t    exp_b[$];

    function automatic int max_of(input int i);
        return (i == 0) ? 59999 : 9;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = M_IDLE;
            m_down[i]  = 1'b0;
            m_steps[i] = 0;
            m_start[i] = 0;
            m_count[i] = 0;
            m_lap[i]   = 0;
        end
        for (int k = 0; k < 3; k++) begin
            ssp_h[k] = 1'b0;
            lap_h[k] = 1'b0;
        end
    endtask

    task automatic push_expected();
        obs_t o [2];
        for (int i = 0; i < 2; i++) begin
            o[i].count   = 16'(m_count[i]);
            o[i].lap     = 16'(m_lap[i]);
            o[i].running = (m_state[i] == M_RUN);
            o[i].alarm   = (m_state[i] == M_DONE);
        end
        exp_a.push_back(o[0]);
        exp_b.push_back(o[1]);
    endtask

    task automatic model_step();
        bit s_ev, l_ev;
        int mx, eff, idle_v, ticks;
        // A press is acted on when the 3rd high sample arrives after a low one.
        s_ev = ssp_h[1] && !ssp_h[2];
        l_ev = lap_h[1] && !lap_h[2];
        ssp_h[2] = ssp_h[1]; ssp_h[1] = ssp_h[0]; ssp_h[0] = ssp;
        lap_h[2] = lap_h[1]; lap_h[1] = lap_h[0]; lap_h[0] = lap;
        for (int i = 0; i < 2; i++) begin
            mx     = max_of(i);
            eff    = (int'(preset) > mx) ? mx : int'(preset);
            idle_v = down ? eff : 0;
            if (clr) begin
                m_state[i] = M_IDLE;
                m_count[i] = idle_v;
            end else begin
                if (l_ev) m_lap[i] = (m_state[i] == M_IDLE) ? 0 : m_count[i];
                case (m_state[i])
                    M_IDLE: begin
                        m_count[i] = idle_v;
                        if (s_ev) begin
                            m_down[i] = down;
                            if (down && eff == 0) begin
                                m_state[i] = M_DONE;
                                m_count[i] = 0;
                            end else begin
                                m_state[i] = M_RUN;
                                m_steps[i] = 0;
                                m_start[i] = eff;
                            end
                        end
                    end
                    M_RUN: begin
                        m_steps[i] += (1 << speed);
                        ticks = m_steps[i] / DIV;
                        if (m_down[i] && (m_start[i] - ticks <= 0)) begin
                            m_count[i] = 0;
                            m_state[i] = M_DONE;
                        end else begin
                            m_count[i] = m_down[i] ? (m_start[i] - ticks) : (ticks % (mx + 1));
                            if (s_ev) m_state[i] = M_PAUSE;
                        end
                    end
                    M_PAUSE: if (s_ev) m_state[i] = M_RUN;
                    M_DONE: begin
                        m_count[i] = 0;
                        if (s_ev) begin
                            m_state[i] = M_IDLE;
                            m_count[i] = idle_v;
                        end
                    end
                    default: m_state[i] = M_IDLE;
                endcase
            end
        end
    endtask

    // Model advances on every edge; an async reset flushes pending entries.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset();
            exp_a.delete();
            exp_b.delete();
        end else begin
            model_step();
        end
        push_expected();
    end

    // Monitor: one expected entry per instance per clock, compared mid-cycle.
    always @(negedge clk) begin
        obs_t ea, eb;
        if (exp_a.size() == 0 || exp_b.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow at %0t: got=%0d want=1", $time, exp_a.size());
        end else begin
            ea = exp_a.pop_front();
            eb = exp_b.pop_front();
            check("a.count",   32'(count_a),   32'(ea.count));
            check("a.lap",     32'(lap_a),     32'(ea.lap));
            check("a.running", 32'(running_a), 32'(ea.running));
            check("a.alarm",   32'(alarm_a),   32'(ea.alarm));
            check("b.count",   32'(count_b),   32'(eb.count));
            check("b.lap",     32'(lap_b),     32'(eb.lap));
            check("b.running", 32'(running_b), 32'(eb.running));
            check("b.alarm",   32'(alarm_b),   32'(eb.alarm));
        end
    end

    // ---------------- stimulus ----------------
    task automatic press_ssp(input int hold);
        @(negedge clk) ssp = 1'b1;
        repeat (hold) @(posedge clk);
        @(negedge clk) ssp = 1'b0;
    endtask

    task automatic press_lap(input int hold);
        @(negedge clk) lap = 1'b1;
        repeat (hold) @(posedge clk);
        @(negedge clk) lap = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset.count", 32'(count_a), 0);
        check("reset.running", 32'(running_a), 0);
        reset = 1'b0;

        // 1x up count: 250 clocks in RUN -> 25 ticks; small instance wraps to 5
        press_ssp(3);
        repeat (250) @(posedge clk);
        #1;
        check("up1x.count", 32'(count_a), 25);
        check("up1x.running", 32'(running_a), 1);
        check("wrap.count", 32'(count_b), 5);
        check("wrap.alarm", 32'(alarm_b), 0);
        press_ssp(3);
        pulse_clr();

        // 8x: 100 clocks in RUN -> 80 ticks
        speed = 2'd3;
        press_ssp(3);
        repeat (100) @(posedge clk);
        #1;
        check("up8x.count", 32'(count_a), 80);
        check("up8x.wrap", 32'(count_b), 0);
        @(negedge clk) speed = 2'd0;
        pulse_clr();

        // Pause at 55 RUN clocks keeps count and fraction
        press_ssp(3);
        repeat (52) @(posedge clk);
        press_ssp(3);
        check("pause.count", 32'(count_a), 5);
        check("pause.running", 32'(running_a), 0);
        repeat (100) @(posedge clk);
        #1;
        check("pause.hold", 32'(count_a), 5);
        press_lap(3);
        check("lap.a", 32'(lap_a), 5);
        check("lap.b", 32'(lap_b), 5);
        press_ssp(3);
        repeat (4) @(posedge clk);
        #1;
        check("resume.before", 32'(count_a), 5);
        @(posedge clk);
        #1;
        check("resume.tick", 32'(count_a), 6);
        press_ssp(3);
        pulse_clr();
        check("clr.running", 32'(running_a), 0);
        check("clr.count", 32'(count_a), 0);
        check("clr.lap_kept", 32'(lap_a), 5);

        // Countdown from 3, then preset 0 goes straight to DONE
        down   = 1'b1;
        preset = 16'd3;
        @(negedge clk);
        check("idle.preset", 32'(count_a), 3);
        press_ssp(3);
        repeat (30) @(posedge clk);
        #1;
        check("down.count", 32'(count_a), 0);
        check("down.alarm", 32'(alarm_a), 1);
        check("down.running", 32'(running_a), 0);
        press_ssp(3);
        check("done.exit_alarm", 32'(alarm_a), 0);
        check("done.exit_count", 32'(count_a), 3);
        preset = 16'd0;
        @(negedge clk);
        press_ssp(3);
        check("zero.alarm", 32'(alarm_a), 1);
        check("zero.running", 32'(running_a), 0);
        press_ssp(3);
        down = 1'b0;

        // Asynchronous reset between edges while running
        press_ssp(3);
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset.count", 32'(count_a), 0);
        check("areset.lap", 32'(lap_a), 0);
        check("areset.running", 32'(running_a), 0);
        check("areset.alarm", 32'(alarm_a), 0);
        #1 reset = 1'b0;

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 23) == 0) ssp = ~ssp;
            if ($urandom_range(0, 39) == 0) lap = ~lap;
            clr = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) down = ~down;
            if ($urandom_range(0, 39) == 0)
                preset = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 25));
        end
        @(negedge clk);
        ssp = 1'b0;
        lap = 1'b0;
        clr = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
